// File: rtl/rp_8bit_idec_stream.sv
// Streaming AVR pre-decoder: assembles two-word instructions, classifies
// each instruction and queues one record per instruction in a small FIFO.
module rp_8bit_idec_stream #(
  parameter int PW    = 22,
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [15:0]   i_code,
  input  logic [PW-1:0] i_adr,
  input  logic          i_flush,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [3:0]    o_cls,
  output logic [4:0]    o_rd,
  output logic [4:0]    o_rr,
  output logic [21:0]   o_imm,
  output logic          o_len,
  output logic [PW-1:0] o_adr,
  output logic          o_err,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_e
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_ALU2 = 4'd1;
  localparam logic [3:0] C_ALUI = 4'd2;
  localparam logic [3:0] C_LDST = 4'd3;
  localparam logic [3:0] C_LDS  = 4'd4;
  localparam logic [3:0] C_STS  = 4'd5;
  localparam logic [3:0] C_JMP  = 4'd6;
  localparam logic [3:0] C_CALL = 4'd7;
  localparam logic [3:0] C_RJMP = 4'd8;
  localparam logic [3:0] C_BR   = 4'd9;
  localparam logic [3:0] C_SKIP = 4'd10;
  localparam logic [3:0] C_MUL  = 4'd11;
  localparam logic [3:0] C_OTH  = 4'd14;
  localparam logic [3:0] C_UND  = 4'd15;

  typedef struct packed {
    logic [3:0]    cls;
    logic [4:0]    rd;
    logic [4:0]    rr;
    logic [21:0]   imm;
    logic          len;
    logic [PW-1:0] adr;
    logic          err;
  } rec_t;

  typedef enum logic [1:0] {
    S_W1,
    S_W2,
    S_RE
  } st_t;

  function automatic logic is_jc(input logic [15:0] c);
    return (c[15:9] == 7'b1001010) && (c[3:2] == 2'b11);
  endfunction

  function automatic logic is2w(input logic [15:0] c);
    return ((c[15:10] == 6'b100100) && (c[3:0] == 4'h0)) || is_jc(c);
  endfunction

  function automatic rec_t dec1(input logic [15:0] c,
                                input logic [PW-1:0] a);
    rec_t r;
    r     = '0;
    r.adr = a;
    r.cls = C_OTH;
    if (c == 16'h0000) begin
      r.cls = C_NOP;
    end else if (c[15:8] == 8'h00) begin
      r.cls = C_UND;
    end else if (c[15:8] == 8'h01) begin
      r.rd = {c[7:4], 1'b0};
      r.rr = {c[3:0], 1'b0};
    end else if (c[15:8] == 8'h02) begin
      r.cls = C_MUL;
      r.rd  = {1'b1, c[7:4]};
      r.rr  = {1'b1, c[3:0]};
    end else if (c[15:8] == 8'h03) begin
      r.cls = C_MUL;
      r.rd  = {2'b10, c[6:4]};
      r.rr  = {2'b10, c[2:0]};
    end else if (c[15:10] == 6'b000100) begin
      r.cls = C_SKIP;
      r.rd  = c[8:4];
      r.rr  = {c[9], c[3:0]};
    end else if (c[15:14] == 2'b00 && c[13:12] != 2'b11) begin
      r.cls = C_ALU2;
      r.rd  = c[8:4];
      r.rr  = {c[9], c[3:0]};
    end else if (c[15:12] inside {4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE}) begin
      r.cls = C_ALUI;
      r.rd  = {1'b1, c[7:4]};
      r.imm = {14'b0, c[11:8], c[3:0]};
    end else if (c[15:14] == 2'b10 && !c[12]) begin
      // ldd/std with displacement q
      r.cls = C_LDST;
      r.imm = {16'b0, c[13], c[11:10], c[2:0]};
      if (c[9]) r.rr = c[8:4];
      else      r.rd = c[8:4];
    end else if (c[15:10] == 6'b100100) begin
      if (c[3:0] inside {4'h1, 4'h2, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE}) begin
        r.cls = C_LDST;
        if (c[9]) r.rr = c[8:4];
        else      r.rd = c[8:4];
      end
    end else if (c[15:10] == 6'b100111) begin
      r.cls = C_MUL;
      r.rd  = c[8:4];
      r.rr  = {c[9], c[3:0]};
    end else if (c[15:8] == 8'h99 || c[15:8] == 8'h9B) begin
      r.cls = C_SKIP;
      r.imm = {14'b0, c[7:0]};
    end else if (c[15:13] == 3'b110) begin
      r.cls = C_RJMP;
      r.imm = {{10{c[11]}}, c[11:0]};
    end else if (c[15:11] == 5'b11110) begin
      r.cls = C_BR;
      r.imm = {{15{c[9]}}, c[9:3]};
    end else if (c[15:10] == 6'b111111) begin
      if (c[3]) begin
        r.cls = C_UND;
      end else begin
        r.cls = C_SKIP;
        r.rr  = c[8:4];
        r.imm = {19'b0, c[2:0]};
      end
    end
    return r;
  endfunction

  function automatic rec_t dec2(input logic [15:0] w1,
                                input logic [PW-1:0] a1,
                                input logic [15:0] w2);
    rec_t r;
    r     = '0;
    r.adr = a1;
    r.len = 1'b1;
    if (is_jc(w1)) begin
      r.cls = w1[1] ? C_CALL : C_JMP;
      r.imm = {w1[8:4], w1[0], w2};
    end else begin
      r.cls = w1[9] ? C_STS : C_LDS;
      r.rd  = w1[8:4];
      r.imm = {6'b0, w2};
    end
    return r;
  endfunction

  st_t            r_st, w_nst;
  logic [15:0]    r_w1, r_hw, w_ldw;
  logic [PW-1:0]  r_a1, r_ha, w_lda, w_nxt;
  logic           w_ld, w_hold, w_push, w_pop, w_acc;
  logic           w_full, w_emp;
  rec_t           w_prec, w_out, w_erec;
  rec_t           r_mem [DEPTH];
  logic [AW:0]    r_wp, r_rp;
  logic [CW-1:0]  r_cnt, r_cnte;

  assign w_emp  = (r_wp == r_rp);
  assign w_full = (r_wp[AW] != r_rp[AW]) &&
                  (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign i_rdy  = ~w_full & (r_st != S_RE);
  assign w_acc  = i_vld & i_rdy;
  assign o_vld  = ~w_emp;
  assign w_pop  = o_vld & o_rdy;
  assign w_nxt  = r_a1 + {{(PW-1){1'b0}}, 1'b1};

  always_comb begin
    w_erec     = '0;
    w_erec.cls = C_UND;
    w_erec.err = 1'b1;
    w_erec.adr = r_a1;
  end

  always_comb begin
    w_nst  = r_st;
    w_push = 1'b0;
    w_prec = '0;
    w_ld   = 1'b0;
    w_ldw  = i_code;
    w_lda  = i_adr;
    w_hold = 1'b0;
    unique case (r_st)
      S_W1: begin
        if (w_acc) begin
          if (is2w(i_code)) begin
            w_ld  = 1'b1;
            w_nst = S_W2;
          end else begin
            w_push = 1'b1;
            w_prec = dec1(i_code, i_adr);
          end
        end
      end
      S_W2: begin
        if (i_flush) begin
          w_nst = S_W1;
        end else if (w_acc) begin
          w_push = 1'b1;
          if (i_adr == w_nxt) begin
            w_prec = dec2(r_w1, r_a1, i_code);
            w_nst  = S_W1;
          end else begin
            w_prec = w_erec;
            w_hold = 1'b1;
            w_nst  = S_RE;
          end
        end
      end
      S_RE: begin
        // replays the held word once the FIFO can take its record
        if (i_flush) begin
          w_nst = S_W1;
        end else if (!w_full) begin
          if (is2w(r_hw)) begin
            w_ld  = 1'b1;
            w_ldw = r_hw;
            w_lda = r_ha;
            w_nst = S_W2;
          end else begin
            w_push = 1'b1;
            w_prec = dec1(r_hw, r_ha);
            w_nst  = S_W1;
          end
        end
      end
      default: w_nst = S_W1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= S_W1;
      r_w1   <= '0;
      r_a1   <= '0;
      r_hw   <= '0;
      r_ha   <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_cnte <= '0;
    end else begin
      r_st <= w_nst;
      if (w_ld) begin
        r_w1 <= w_ldw;
        r_a1 <= w_lda;
      end
      if (w_hold) begin
        r_hw <= i_code;
        r_ha <= i_adr;
      end
      if (w_push) r_wp <= r_wp + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rp <= r_rp + {{AW{1'b0}}, 1'b1};
      if (w_push && !w_prec.err && r_cnt != {CW{1'b1}})
        r_cnt <= r_cnt + CW'(1);
      if (w_push && w_prec.err && r_cnte != {CW{1'b1}})
        r_cnte <= r_cnte + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_prec;
  end

  assign w_out   = w_emp ? '0 : r_mem[r_rp[AW-1:0]];
  assign o_cls   = w_out.cls;
  assign o_rd    = w_out.rd;
  assign o_rr    = w_out.rr;
  assign o_imm   = w_out.imm;
  assign o_len   = w_out.len;
  assign o_adr   = w_out.adr;
  assign o_err   = w_out.err;
  assign o_cnt   = r_cnt;
  assign o_cnt_e = r_cnte;

endmodule

// File: tb/tb_rp_8bit_idec_stream.sv
// Directed bench for rp_8bit_idec_stream: expected records are queued as
// words are driven and matched against every record the DUT hands out.
module tb_rp_8bit_idec_stream;

  localparam int PW    = 22;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vld, i_rdy, i_flush;
  logic [15:0]   i_code;
  logic [PW-1:0] i_adr;
  logic          o_vld, o_rdy;
  logic [3:0]    o_cls;
  logic [4:0]    o_rd, o_rr;
  logic [21:0]   o_imm;
  logic          o_len, o_err;
  logic [PW-1:0] o_adr;
  logic [CW-1:0] o_cnt, o_cnt_e;

  typedef struct packed {
    logic [3:0]    cls;
    logic [4:0]    rd;
    logic [4:0]    rr;
    logic [21:0]   imm;
    logic          len;
    logic [PW-1:0] adr;
    logic          err;
  } rec_t;

  rec_t q[$];
  rec_t w_obs;
  rec_t m_e;
  int   total = 0;
  int   bad = 0;
  int   exp_good = 0;
  int   exp_err = 0;

  always #5 clk = ~clk;

  rp_8bit_idec_stream #(.PW(PW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_code(i_code), .i_adr(i_adr),
    .i_flush(i_flush),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_cls(o_cls), .o_rd(o_rd),
    .o_rr(o_rr), .o_imm(o_imm), .o_len(o_len), .o_adr(o_adr),
    .o_err(o_err), .o_cnt(o_cnt), .o_cnt_e(o_cnt_e)
  );

  assign w_obs = {o_cls, o_rd, o_rr, o_imm, o_len, o_adr, o_err};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_vld && o_rdy) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_rec observed=%h expected=none", w_obs);
      end else begin
        m_e = q.pop_front();
        chk("record", 64'(w_obs), 64'(m_e));
      end
    end
  end

  task automatic expect_rec(input logic [3:0] cls, input logic [4:0] rd,
                            input logic [4:0] rr, input logic [21:0] imm,
                            input logic len, input logic [PW-1:0] adr,
                            input logic err);
    rec_t r;
    r.cls = cls; r.rd = rd; r.rr = rr; r.imm = imm;
    r.len = len; r.adr = adr; r.err = err;
    q.push_back(r);
    if (err) exp_err++;
    else     exp_good++;
  endtask

  task automatic send(input logic [15:0] c, input logic [PW-1:0] a);
    logic ok;
    int   n;
    ok = 1'b0;
    n = 0;
    i_vld = 1'b1; i_code = c; i_adr = a;
    while (!ok && n < 50) begin
      @(negedge clk) ok = i_rdy;
      @(posedge clk); #1;
      n++;
    end
    i_vld = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=no_accept expected=accept code=%h", c);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || o_vld) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $error("FAIL drain_timeout observed=%0d_left expected=0", q.size());
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    rst = 1'b1; i_vld = 1'b0; i_code = '0; i_adr = '0;
    i_flush = 1'b0; o_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(o_vld), 64'(0));
    chk("rst_rdy", 64'(i_rdy), 64'(1));
    chk("rst_cnt", 64'(o_cnt), 64'(0));
    chk("rst_cnte", 64'(o_cnt_e), 64'(0));
    chk("rst_rec", 64'(w_obs), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // NOP, one-cycle latency
    o_rdy = 1'b1;
    expect_rec(4'd0, 5'd0, 5'd0, 22'h0, 1'b0, 22'h010, 1'b0);
    send(16'h0000, 22'h010);
    chk("t1_vld", 64'(o_vld), 64'(1));
    chk("t1_cnt", 64'(o_cnt), 64'(1));
    drain();

    // call 0x3FFFFF
    expect_rec(4'd7, 5'd0, 5'd0, 22'h3FFFFF, 1'b1, 22'h020, 1'b0);
    send(16'h95FF, 22'h020);
    send(16'hFFFF, 22'h021);
    drain();

    // single-word decode table
    expect_rec(4'd1, 5'd1, 5'd2, 22'h0, 1'b0, 22'h100, 1'b0);
    send(16'h0C12, 22'h100);
    expect_rec(4'd8, 5'd0, 5'd0, 22'h3FFFFF, 1'b0, 22'h101, 1'b0);
    send(16'hCFFF, 22'h101);
    expect_rec(4'd9, 5'd0, 5'd0, 22'h3FFFFF, 1'b0, 22'h102, 1'b0);
    send(16'hF3F9, 22'h102);
    expect_rec(4'd10, 5'd0, 5'd0, 22'h7, 1'b0, 22'h103, 1'b0);
    send(16'h9907, 22'h103);
    expect_rec(4'd11, 5'd1, 5'd2, 22'h0, 1'b0, 22'h104, 1'b0);
    send(16'h9C12, 22'h104);
    expect_rec(4'd15, 5'd0, 5'd0, 22'h0, 1'b0, 22'h105, 1'b0);
    send(16'h0001, 22'h105);
    expect_rec(4'd3, 5'd5, 5'd0, 22'h0, 1'b0, 22'h106, 1'b0);
    send(16'h905D, 22'h106);
    expect_rec(4'd3, 5'd0, 5'd7, 22'h3, 1'b0, 22'h107, 1'b0);
    send(16'h827B, 22'h107);
    expect_rec(4'd14, 5'd0, 5'd0, 22'h0, 1'b0, 22'h108, 1'b0);
    send(16'h9508, 22'h108);
    drain();

    // lds / sts
    expect_rec(4'd4, 5'd30, 5'd0, 22'h1234, 1'b1, 22'h070, 1'b0);
    send(16'h91E0, 22'h070);
    send(16'h1234, 22'h071);
    expect_rec(4'd5, 5'd0, 5'd0, 22'hABCD, 1'b1, 22'h072, 1'b0);
    send(16'h9200, 22'h072);
    send(16'hABCD, 22'h073);
    drain();

    // address break inside lds, held ldi replayed
    expect_rec(4'd15, 5'd0, 5'd0, 22'h0, 1'b0, 22'h030, 1'b1);
    expect_rec(4'd2, 5'd31, 5'd0, 22'h05, 1'b0, 22'h040, 1'b0);
    send(16'h9100, 22'h030);
    send(16'hE0F5, 22'h040);
    drain();
    chk("t3_cnte", 64'(o_cnt_e), 64'(1));

    // address break where the held word is itself a jmp
    expect_rec(4'd15, 5'd0, 5'd0, 22'h0, 1'b0, 22'h080, 1'b1);
    expect_rec(4'd6, 5'd0, 5'd0, 22'h5, 1'b1, 22'h090, 1'b0);
    send(16'h9000, 22'h080);
    send(16'h940C, 22'h090);
    send(16'h0005, 22'h091);
    drain();

    // backpressure: FIFO fills, then releases in order
    o_rdy = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      expect_rec(4'd2, 5'(16 + i), 5'd0, 22'(i), 1'b0, 22'(32'hA0 + i), 1'b0);
    for (int i = 0; i < DEPTH; i++)
      send(16'hE000 | 16'(i << 4) | 16'(i), 22'(32'hA0 + i));
    i_vld = 1'b1;
    i_code = 16'hE000 | 16'(DEPTH << 4) | 16'(DEPTH);
    i_adr = 22'(32'hA0 + DEPTH);
    @(negedge clk);
    chk("t4_full_rdy", 64'(i_rdy), 64'(0));
    chk("t4_full_vld", 64'(o_vld), 64'(1));
    @(posedge clk); #1;
    o_rdy = 1'b1;
    send(16'hE000 | 16'(DEPTH << 4) | 16'(DEPTH), 22'(32'hA0 + DEPTH));
    drain();

    // flush drops pending call and same-cycle word
    expect_rec(4'd0, 5'd0, 5'd0, 22'h0, 1'b0, 22'h060, 1'b0);
    send(16'h940E, 22'h050);
    i_flush = 1'b1; i_vld = 1'b1; i_code = 16'h0000; i_adr = 22'h051;
    @(negedge clk);
    chk("t5_flush_rdy", 64'(i_rdy), 64'(1));
    @(posedge clk); #1;
    i_flush = 1'b0; i_vld = 1'b0;
    send(16'h0000, 22'h060);
    drain();

    // jmp across address wrap
    expect_rec(4'd6, 5'd0, 5'd0, 22'h000001, 1'b1, 22'h3FFFFF, 1'b0);
    send(16'h940C, 22'h3FFFFF);
    send(16'h0001, 22'h000000);
    drain();

    chk("cnt_sat", 64'(o_cnt), 64'(sat(exp_good)));
    chk("cnte", 64'(o_cnt_e), 64'(exp_err));

    // reset while a jmp is half assembled
    send(16'h940C, 22'h0B0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_vld", 64'(o_vld), 64'(0));
    chk("mid_rst_cnt", 64'(o_cnt), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    expect_rec(4'd0, 5'd0, 5'd0, 22'h0, 1'b0, 22'h0B1, 1'b0);
    send(16'h0000, 22'h0B1);
    drain();
    chk("post_rst_cnt", 64'(o_cnt), 64'(1));
    chk("q_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
